dmem_lsu: RTL

- Load/store sequencer between the core's memory stage and the 1024-byte, byte-wide data RAM.
- Accepts one RV32 load or store per handshake: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Serialises each access into little-endian byte accesses on the RAM's write/read ports.
- Assembles and sign/zero-extends load data, flags misaligned or illegal accesses, and signals completion with a one-cycle done pulse.

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_lsu_if.sv | 32 +++
 rtl/dmem_lsu_load_ext.sv | 25 ++
 rtl/dmem_lsu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store sequencer: funct3 codes,
// sequencer states and the access decode helpers.
package dmem_pkg;

  localparam int RAM_ADDR_W = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  // Number of bytes moved by an access of the given funct3.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    logic [2:0] n;
    case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // True when funct3 is legal for the direction and the address is aligned.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic legal;
    logic aligned;
    case (f3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = 1'b1;
      F3_W:    legal = 1'b1;
      F3_BU:   legal = ~we;
      F3_HU:   legal = ~we;
      default: legal = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   aligned = ~a[0];
      2'b10:   aligned = (a == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response and RAM-port bundle of the load/store sequencer.
interface dmem_lsu_if #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
);
  logic              i_req;
  logic              i_we;
  logic [XLEN-1:0]   i_addr;
  logic [2:0]        i_funct3;
  logic [XLEN-1:0]   i_wdata;
  logic              o_ready;
  logic              o_done;
  logic              o_err;
  logic [XLEN-1:0]   o_rdata;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_waddr;
  logic [7:0]        o_ram_wdata;
  logic [ADDR_W-1:0] o_ram_raddr;
  logic [7:0]        i_ram_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_funct3, i_wdata, i_ram_rdata,
    output o_ready, o_done, o_err, o_rdata,
           o_ram_we, o_ram_waddr, o_ram_wdata, o_ram_raddr
  );

  modport master (
    output i_req, i_we, i_addr, i_funct3, i_wdata, i_ram_rdata,
    input  o_ready, o_done, o_err, o_rdata,
           o_ram_we, o_ram_waddr, o_ram_wdata, o_ram_raddr
  );
endinterface

// File: rtl/dmem_lsu_load_ext.sv
// Sign/zero extension of the captured load bytes according to funct3.
module load_ext
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [31:0]     data,
  output logic [XLEN-1:0] result
);

  // Select width and extension from funct3.
  always_comb begin
    result = {XLEN{1'b0}};
    case (funct3)
      F3_B:    result = {{(XLEN-8){data[7]}}, data[7:0]};
      F3_H:    result = {{(XLEN-16){data[15]}}, data[15:0]};
      F3_W:    result = XLEN'(data);
      F3_BU:   result = XLEN'(data[7:0]);
      F3_HU:   result = XLEN'(data[15:0]);
      default: result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer: splits one RV32 access into little-endian byte
// accesses on a byte-wide RAM with a one-cycle read latency.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int XLEN   = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_lsu_if.slave bus
);

  lsu_state_t        state_r, state_s;
  logic [2:0]        cnt_r, cnt_s, num_r, num_s, f3_r, f3_s;
  logic [2:0]        cnt_inc_s, cap_idx_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [31:0]       wdata_r, wdata_s, bytes_r, bytes_s, cap_bytes_s;
  logic              ready_r, ready_s, done_r, done_s, err_r, err_s;
  logic [XLEN-1:0]   rdata_r, rdata_s, ext_s;
  logic              ram_we_r, ram_we_s;
  logic [ADDR_W-1:0] waddr_r, waddr_s, raddr_r, raddr_s;
  logic [7:0]        wbyte_r, wbyte_s;
  logic              unused_addr_s;

  assign cnt_inc_s     = cnt_r + 3'd1;
  assign cap_idx_s     = cnt_r - 3'd1;
  assign unused_addr_s = ^bus.i_addr[XLEN-1:ADDR_W];

  // Load bytes including the one arriving this cycle; cnt_r counts LOAD cycles
  // already spent, so the RAM is returning the byte issued one cycle earlier.
  always_comb begin
    cap_bytes_s = bytes_r;
    if (state_r == LOAD && cnt_r != 3'd0) begin
      cap_bytes_s[{cap_idx_s[1:0], 3'b000} +: 8] = bus.i_ram_rdata;
    end else begin
      cap_bytes_s = bytes_r;
    end
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3 (f3_r),
    .data   (cap_bytes_s),
    .result (ext_s)
  );

  // Next-state and next-output logic; RAM strobes default to idle zeros.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    num_s    = num_r;
    f3_s     = f3_r;
    base_s   = base_r;
    wdata_s  = wdata_r;
    bytes_s  = bytes_r;
    rdata_s  = rdata_r;
    done_s   = 1'b0;
    err_s    = 1'b0;
    ram_we_s = 1'b0;
    waddr_s  = {ADDR_W{1'b0}};
    wbyte_s  = 8'h00;
    raddr_s  = {ADDR_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.i_req) begin
          base_s  = bus.i_addr[ADDR_W-1:0];
          f3_s    = bus.i_funct3;
          wdata_s = bus.i_wdata[31:0];
          num_s   = byte_count(bus.i_funct3);
          cnt_s   = 3'd0;
          bytes_s = 32'h0000_0000;
          if (!access_ok(bus.i_we, bus.i_funct3, bus.i_addr[1:0])) begin
            state_s = DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else if (bus.i_we) begin
            state_s  = STORE;
            ram_we_s = 1'b1;
            waddr_s  = bus.i_addr[ADDR_W-1:0];
            wbyte_s  = bus.i_wdata[7:0];
          end else begin
            state_s = LOAD;
            raddr_s = bus.i_addr[ADDR_W-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end
      STORE: begin
        if (cnt_inc_s == num_r) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          cnt_s    = cnt_inc_s;
          ram_we_s = 1'b1;
          waddr_s  = base_r + ADDR_W'(cnt_inc_s);
          wbyte_s  = wdata_r[{cnt_inc_s[1:0], 3'b000} +: 8];
        end
      end
      LOAD: begin
        bytes_s = cap_bytes_s;
        if (cnt_r == num_r) begin
          state_s = DONE;
          done_s  = 1'b1;
          rdata_s = ext_s;
        end else begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s < num_r) begin
            raddr_s = base_r + ADDR_W'(cnt_inc_s);
          end else begin
            raddr_s = {ADDR_W{1'b0}};
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ready_s = (state_s == IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 3'd0;
      num_r    <= 3'd0;
      f3_r     <= 3'd0;
      base_r   <= {ADDR_W{1'b0}};
      wdata_r  <= 32'h0000_0000;
      bytes_r  <= 32'h0000_0000;
      rdata_r  <= {XLEN{1'b0}};
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ram_we_r <= 1'b0;
      waddr_r  <= {ADDR_W{1'b0}};
      wbyte_r  <= 8'h00;
      raddr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      num_r    <= num_s;
      f3_r     <= f3_s;
      base_r   <= base_s;
      wdata_r  <= wdata_s;
      bytes_r  <= bytes_s;
      rdata_r  <= rdata_s;
      ready_r  <= ready_s;
      done_r   <= done_s;
      err_r    <= err_s;
      ram_we_r <= ram_we_s;
      waddr_r  <= waddr_s;
      wbyte_r  <= wbyte_s;
      raddr_r  <= raddr_s;
    end
  end

  assign bus.o_ready     = ready_r;
  assign bus.o_done      = done_r;
  assign bus.o_err       = err_r;
  assign bus.o_rdata     = rdata_r;
  assign bus.o_ram_we    = ram_we_r;
  assign bus.o_ram_waddr = waddr_r;
  assign bus.o_ram_wdata = wbyte_r;
  assign bus.o_ram_raddr = raddr_r;

endmodule
